best_ruler_tracker: RTL and testbench

BEST_RULER_TRACKER -- requirements
Module: best_ruler_tracker

---
 rtl/best_ruler_tracker.sv | 106 ++++++++++
 tb/tb_best_ruler_tracker.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/best_ruler_tracker.sv
// best_ruler_tracker: keeps the shortest ruler found by the leaf counter and feeds back a shrinking limit.
// Optional statistics counters are built only when BEST_RULER_STATS_EN is defined.
module best_ruler_tracker #(
   parameter int NUMPOSITIONS = 5,
   parameter int MAXVALUE     = 500
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          start,
   input  logic [8:0]                    init_limit,
   input  logic [6:0]                    enabled,
   input  logic                          success,
   input  logic [8:0]                    leaf_val,
   input  logic [(NUMPOSITIONS+1)*9-1:0] marks_in,
   output logic [8:0]                    limit,
   output logic [(NUMPOSITIONS+1)*9-1:0] result_marks,
   output logic                          result_valid,
   input  logic                          result_ready,
   output logic [8:0]                    best_length,
   output logic                          done,
   output logic [15:0]                   found_count,
   output logic [15:0]                   overwrite_count
);
   localparam int W = (NUMPOSITIONS + 1) * 9;
   localparam logic [8:0] MAXV = 9'(MAXVALUE);

   typedef enum logic [1:0] {IDLE, SEARCH, DRAIN, DONE} state_t;

   state_t         state_q, state_d;
   logic [8:0]     limit_q, limit_d;
   logic [8:0]     best_q, best_d;
   logic [W-1:0]   marks_q, marks_d;
   logic           valid_q, valid_d;
   logic           capture, handshake, overwrite;

   assign capture   = (state_q == SEARCH) && success && (leaf_val <= limit_q) && (leaf_val != 9'd0);
   assign handshake = valid_q && result_ready;
   assign overwrite = capture && valid_q && !result_ready;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         limit_q <= '0;
         best_q  <= '0;
         marks_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         limit_q <= limit_d;
         best_q  <= best_d;
         marks_q <= marks_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      limit_d = limit_q;
      best_d  = best_q;
      marks_d = marks_q;
      valid_d = handshake ? 1'b0 : valid_q;
      if (capture) begin
         marks_d = {marks_in[W-1:9], leaf_val};
         best_d  = leaf_val;
         limit_d = leaf_val - 9'd1;
         valid_d = 1'b1;
      end
      case (state_q)
         IDLE, DONE: if (start) begin
            state_d = SEARCH;
            limit_d = (init_limit > MAXV) ? MAXV : init_limit;
            best_d  = '0;
         end
         // a capture in the exhausting cycle leaves a result that must still drain
         SEARCH: if (enabled == 7'd0) state_d = (valid_q || capture) ? DRAIN : DONE;
         DRAIN: if (!valid_q) state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   assign limit        = limit_q;
   assign best_length  = best_q;
   assign result_marks = marks_q;
   assign result_valid = valid_q;
   assign done         = (state_q == DONE);

`ifdef BEST_RULER_STATS_EN
   logic [15:0] found_q, over_q;
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         found_q <= '0;
         over_q  <= '0;
      end else begin
         if (capture && found_q != 16'hFFFF) found_q <= found_q + 16'd1;
         if (overwrite && over_q != 16'hFFFF) over_q <= over_q + 16'd1;
      end
   end
   assign found_count     = found_q;
   assign overwrite_count = over_q;
`else
   logic unused_ovr;
   assign unused_ovr      = overwrite;
   assign found_count     = '0;
   assign overwrite_count = '0;
`endif
endmodule

// File: tb/tb_best_ruler_tracker.sv
// tb_best_ruler_tracker: directed vectors with hand-computed expectations for best_ruler_tracker.
module tb_best_ruler_tracker;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [8:0]  init_limit = '0;
   logic [6:0]  enabled = '0;
   logic        success = 1'b0;
   logic [8:0]  leaf_val = '0;
   logic [53:0] marks_in = '0;
   logic        result_ready = 1'b0;
   logic [8:0]  limit, best_length;
   logic [53:0] result_marks;
   logic        result_valid, done;
   logic [15:0] found_count, overwrite_count;
   int checks = 0;
   int errors = 0;

   best_ruler_tracker dut (
      .clock(clock), .reset(reset), .start(start), .init_limit(init_limit),
      .enabled(enabled), .success(success), .leaf_val(leaf_val), .marks_in(marks_in),
      .limit(limit), .result_marks(result_marks), .result_valid(result_valid),
      .result_ready(result_ready), .best_length(best_length), .done(done),
      .found_count(found_count), .overwrite_count(overwrite_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [53:0] pack(input int a, b, c, d, e, f);
      return {9'(a), 9'(b), 9'(c), 9'(d), 9'(e), 9'(f)};
   endfunction

   function automatic logic [15:0] stat(input int v);
`ifdef BEST_RULER_STATS_EN
      return 16'(v);
`else
      return 16'(v) & 16'h0;
`endif
   endfunction

   initial begin
      #2;
      check("rst_limit", limit, 0);
      check("rst_valid", result_valid, 0);
      check("rst_best", best_length, 0);
      check("rst_done", done, 0);
      check("rst_marks", result_marks, 0);
      check("rst_found", found_count, 0);
      tick();
      reset = 1'b0;
      start = 1'b1; init_limit = 9'd30; enabled = 7'd5;
      tick();
      start = 1'b0;
      check("start_limit", limit, 30);
      check("start_done", done, 0);
      success = 1'b1; leaf_val = 9'd17; marks_in = pack(0, 1, 4, 10, 12, 99);
      tick();
      check("cap_limit", limit, 16);
      check("cap_best", best_length, 17);
      check("cap_marks", result_marks, pack(0, 1, 4, 10, 12, 17));
      check("cap_valid", result_valid, 1);
      tick(); tick(); tick();
      check("hold_limit", limit, 16);
      check("hold_found", found_count, stat(1));
      check("hold_best", best_length, 17);
      // fresh search for the overwrite scenario
      success = 1'b0;
      #2 reset = 1'b1;
      #1 check("rst2_valid", result_valid, 0);
      tick();
      reset = 1'b0; start = 1'b1; init_limit = 9'd30;
      tick();
      start = 1'b0;
      success = 1'b1; leaf_val = 9'd25; marks_in = pack(0, 2, 7, 13, 20, 0);
      tick();
      check("c25_limit", limit, 24);
      leaf_val = 9'd20; marks_in = pack(0, 3, 5, 11, 19, 0);
      tick();
      check("ovw_marks", result_marks, pack(0, 3, 5, 11, 19, 20));
      check("ovw_limit", limit, 19);
      check("ovw_valid", result_valid, 1);
      check("ovw_count", overwrite_count, stat(1));
      check("ovw_found", found_count, stat(2));
      leaf_val = 9'd18; result_ready = 1'b1;
      tick();
      check("hs_cap_valid", result_valid, 1);
      check("hs_cap_limit", limit, 17);
      check("hs_cap_ovw", overwrite_count, stat(1));
      check("hs_cap_marks", result_marks, pack(0, 3, 5, 11, 19, 18));
      success = 1'b0;
      tick();
      check("hs_clear", result_valid, 0);
      result_ready = 1'b0; success = 1'b1; leaf_val = 9'd0;
      tick();
      check("zero_leaf", limit, 17);
      check("zero_leaf_v", result_valid, 0);
      leaf_val = 9'd18;
      tick();
      check("above_limit", limit, 17);
      leaf_val = 9'd17;
      tick();
      check("eq_limit", limit, 16);
      check("eq_valid", result_valid, 1);
      success = 1'b0; enabled = 7'd0;
      tick();
      check("drain_done", done, 0);
      success = 1'b1; leaf_val = 9'd5;
      tick();
      check("drain_nocap", limit, 16);
      check("drain_valid", result_valid, 1);
      success = 1'b0; result_ready = 1'b1;
      tick();
      check("drain_hs_v", result_valid, 0);
      check("drain_hs_d", done, 0);
      result_ready = 1'b0;
      tick();
      check("done_set", done, 1);
      success = 1'b1; leaf_val = 9'd3;
      tick(); tick();
      check("done_limit", limit, 16);
      check("done_hold", done, 1);
      // restart from DONE, capture while exhausting
      success = 1'b0; start = 1'b1; init_limit = 9'd30; enabled = 7'd5;
      tick();
      start = 1'b0;
      check("restart_limit", limit, 30);
      check("restart_done", done, 0);
      check("restart_best", best_length, 0);
      success = 1'b1; leaf_val = 9'd10; enabled = 7'd0;
      tick();
      success = 1'b0;
      check("capx_valid", result_valid, 1);
      check("capx_limit", limit, 9);
      tick();
      check("capx_drain", done, 0);
      #2 reset = 1'b1;
      #1;
      check("arst_valid", result_valid, 0);
      check("arst_limit", limit, 0);
      check("arst_marks", result_marks, 0);
      check("arst_best", best_length, 0);
      check("arst_ovw", overwrite_count, 0);
      tick();
      reset = 1'b0; start = 1'b1; init_limit = 9'd500; enabled = 7'd3;
      init_limit = 9'h1FF;
      tick();
      start = 1'b0;
      check("clamp_limit", limit, 500);
      enabled = 7'd0;
      tick();
      check("empty_done", done, 1);
      check("empty_valid", result_valid, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
